sd_cmd_engine: RTL
==================

Name: sd_cmd_engine

Overview:
Parametrised second-generation SD command-path controller between the host register interface and the serial physical layer.
- Builds the full 48-bit command frame: start bit, transmission bit, index, argument, CRC7 and end bit.
- Decodes the expected response type from the command index and waits for the response with an internal timeout counter.
- Checks the response index and CRC7, and retries failed commands a configurable number of times.

Parameters:
TIMEOUT_CYCLES, 64, cycles allowed in WAIT_RESP from entry to strobe_in before timeout (>=2)
MAX_RETRIES, 2, extra transmissions after a timeout or CRC error (0 = no retry)
CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived, not overridden)

Ports:
clock  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-low reset
new_command  in  1  host request; sampled only in IDLE
cmd_index  in  6  command index; held by host until command_complete
cmd_argument  in  32  command argument; held by host until command_complete
busy  out  1  high from the cycle after acceptance until return to IDLE
response  out  128  latched response payload
command_complete  out  1  one-cycle pulse on entry to DONE
command_index_error  out  1  index mismatch on the final attempt (valid with command_complete)
command_timeout  out  1  no response on the final attempt
crc_error  out  1  CRC7 mismatch on the final attempt
retry_count  out  2  attempts used beyond the first
strobe_out  out  1  frame valid to the physical layer
cmd_out  out  48  {2'b01, index, argument, crc7, 1'b1}
idle_out  out  1  high in IDLE
ack_out  out  1  response consumed; held in DONE
serial_ready  in  1  physical layer has shifted out the frame
strobe_in  in  1  one-cycle pulse: cmd_in valid
cmd_in  in  136  received response, MSB first, right-aligned for 48-bit responses
ack_in  in  1  physical layer releases the response

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a clock edge) takes effect from any state, mid-frame included:
  - state goes to IDLE;
  - response, cmd_out, retry_count and counters go to 0;
  - every flag goes to 0 except idle_out, which goes to 1.
- Response type is decoded from cmd_index:
  - NONE: indices 0, 4, 15.
  - R2: indices 2, 9, 10. Response is 136 bits: response <= {cmd_in[127:8], 8'h00}. CRC is checked over cmd_in[127:8] against cmd_in[7:1]. No index check.
  - R3: index 41. response[31:0] <= cmd_in[39:8]. No index check and no CRC check.
  - R1B: index 12. response[127:96] <= cmd_in[39:8]. Index and CRC are checked.
  - R1: all other indices. response[31:0] <= cmd_in[39:8]. Index check: cmd_in[45:40]==cmd_index. CRC is checked over cmd_in[47:8] against cmd_in[7:1].
  - Bits of response outside the written field are cleared at command acceptance.
- CRC7 uses polynomial x^7+x^3+1 with a zero seed. The transmit CRC covers cmd_out[47:8].
- IDLE:
  - idle_out=1, busy=0, strobe_out=0.
  - On new_command=1: latch cmd_index and cmd_argument, build cmd_out, set retry_count=0 and clear response and all error flags, then go to SEND.
- SEND:
  - strobe_out=1 and busy=1; cmd_out is stable.
  - When serial_ready=1 is sampled, strobe_out drops the next cycle.
  - Type NONE goes to DONE; all other types go to WAIT_RESP with counter=0.
- WAIT_RESP:
  - The counter increments every cycle.
  - strobe_in=1: latch the payload and go to CHECK.
  - Otherwise, when counter==TIMEOUT_CYCLES-1, a timeout occurs.
  - If strobe_in=1 arrives in the terminal cycle, strobe_in wins.
- CHECK (one cycle): compute idx_err and crc_err.
  - crc_err with retries left: retry_count+1, go to SEND.
  - Otherwise: set the flags and go to DONE.
  - An index error alone never triggers a retry.
- Timeout:
  - With retries left: retry_count+1, go to SEND.
  - Otherwise: set command_timeout and go to DONE. response is left unchanged.
- A retry retransmits the identical cmd_out.
- DONE:
  - command_complete pulses on the first cycle only; ack_out=1 and busy=1 throughout.
  - When ack_in=1 is sampled, go to IDLE. If ack_in is already high, DONE lasts exactly one cycle.
- new_command is ignored outside IDLE.
- response and the error flags hold until the next acceptance.
- Minimum latency for a NONE command: acceptance, then 1 cycle of SEND when serial_ready is already high, then DONE.

Decomposition:
- Package sd_cmd_pkg holds:
  - resp_type_e enum {NONE, R1, R1B, R2, R3};
  - function resp_type_of(index);
  - state enum {IDLE, SEND, WAIT_RESP, CHECK, DONE};
  - constants START_BITS=2'b01 and END_BIT=1'b1.
- Sub-module sd_crc7: parametrised data width (40 or 120 bits), combinational 7-bit CRC. Instantiated once for transmit and once for receive, time-multiplexed between the R1 and R2 receive widths.

Test Plan:
- CMD0, argument 0, serial_ready high after 3 cycles:
  - cmd_out = 48'h40_0000_0000_95;
  - DONE with no WAIT_RESP, command_complete pulses once, all flags 0.
- CMD17, argument 32'h0000_0200, valid R1 response with index 17 and correct CRC:
  - response[31:0]=cmd_in[39:8];
  - command_index_error=0, crc_error=0, retry_count=0.
- CMD2, R2 response with correct CRC:
  - response[127:8]=cmd_in[127:8];
  - no index check even though cmd_in[45:40]!=2.
- CMD8 with no strobe_in, MAX_RETRIES=2, TIMEOUT_CYCLES=64:
  - exactly 3 SEND phases;
  - command_timeout=1 and retry_count=2 after 3×64 cycles of WAIT_RESP.
- CMD13 response with a corrupted CRC on the first attempt and good on the second:
  - retry_count=1, crc_error=0, response valid.
- Reset driven to 0 during WAIT_RESP, then new_command while busy:
  - after reset: idle_out=1 and strobe_out=0 the next cycle;
  - the new_command issued while busy is ignored.

Source files
------------

// File: rtl/sd_cmd_engine_pkg.sv
// sd_cmd_pkg
//   Shared types and constants for the SD command-path engine:
//   - resp_type_e : response format expected for a command index
//   - state_e     : command engine FSM states
//   - resp_type_of: maps a 6-bit command index onto its response format
//   - START_BITS / END_BIT: fixed framing bits of a 48-bit command
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    NONE,
    R1,
    R1B,
    R2,
    R3
  } resp_type_e;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_RESP,
    CHECK,
    DONE
  } state_e;

  localparam logic [1:0] START_BITS = 2'b01;
  localparam logic       END_BIT    = 1'b1;

  function automatic resp_type_e resp_type_of(input logic [5:0] index);
    resp_type_e t;
    case (index)
      6'd0, 6'd4, 6'd15:  t = NONE;
      6'd2, 6'd9, 6'd10:  t = R2;
      6'd41:              t = R3;
      6'd12:              t = R1B;
      default:            t = R1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sd_cmd_engine_crc7.sv
// sd_crc7
//   Combinational CRC7 (x^7 + x^3 + 1, zero seed) over DATA_W bits,
//   most significant bit first.
//   Ports:
//     data  in  DATA_W  bits to protect, MSB shifted first
//     crc   out 7       resulting CRC7
module sd_crc7 #(
  parameter int DATA_W = 40
) (
  input  logic [DATA_W-1:0] data,
  output logic [6:0]        crc
);

  logic [6:0] acc;
  logic       fb;

  // Bit-serial LFSR unrolled across the whole word. Because the seed is
  // zero, leading zero bits leave the register untouched, so a short
  // message can be right-aligned into a wider instance.
  always_comb begin
    acc = 7'd0;
    fb  = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb  = data[i] ^ acc[6];
      acc = {acc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    end
    crc = acc;
  end

endmodule

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine
//   SD command-path controller: frames a host command, hands it to the
//   serial layer, waits for the response with a timeout, checks index and
//   CRC7, and retransmits on timeout or CRC failure.
//   Ports:
//     clock, reset               clock, synchronous active-low reset
//     new_command, cmd_index,    host request (sampled in IDLE), index and
//     cmd_argument               argument held until command_complete
//     busy, idle_out             engine activity indicators
//     response                   latched 128-bit response payload
//     command_complete           one-cycle pulse on entry to DONE
//     command_index_error,       final-attempt status flags
//     command_timeout, crc_error
//     retry_count                attempts used beyond the first
//     strobe_out, cmd_out        48-bit frame offered to the serial layer
//     serial_ready               serial layer has shifted the frame out
//     strobe_in, cmd_in          received response pulse and payload
//     ack_out, ack_in            response handshake in DONE
module sd_cmd_engine
  import sd_cmd_pkg::*;
#(
  parameter int  TIMEOUT_CYCLES = 64,
  parameter int  MAX_RETRIES    = 2,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         new_command,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_argument,
  output logic         busy,
  output logic [127:0] response,
  output logic         command_complete,
  output logic         command_index_error,
  output logic         command_timeout,
  output logic         crc_error,
  output logic [1:0]   retry_count,
  output logic         strobe_out,
  output logic [47:0]  cmd_out,
  output logic         idle_out,
  output logic         ack_out,
  input  logic         serial_ready,
  input  logic         strobe_in,
  input  logic [135:0] cmd_in,
  input  logic         ack_in
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       MAX_R    = MAX_RETRIES[1:0];

  state_e           state;
  resp_type_e       rtype;
  logic [CNT_W-1:0] counter;
  logic [127:1]     rx;
  logic [6:0]       tx_crc;
  logic [6:0]       rx_crc;
  logic [119:0]     rx_crc_data;
  logic             idx_err;
  logic             crc_err;
  logic             retries_left;

  // The transmit CRC is taken from the live host inputs because the frame
  // is assembled on the same edge that accepts the command.
  sd_crc7 #(.DATA_W(40)) u_tx_crc (
    .data ({START_BITS, cmd_index, cmd_argument}),
    .crc  (tx_crc)
  );

  // One 120-bit receive checker serves both response widths: a 40-bit R1
  // body is right-aligned with zero padding, which a zero-seeded CRC ignores.
  sd_crc7 #(.DATA_W(120)) u_rx_crc (
    .data (rx_crc_data),
    .crc  (rx_crc)
  );

  // Response checks evaluated during CHECK. R2 carries no echoed index and
  // R3 carries no valid CRC, so those checks are masked by type.
  always_comb begin
    rx_crc_data  = (rtype == R2) ? rx[127:8] : {80'd0, rx[47:8]};
    idx_err      = ((rtype == R1) || (rtype == R1B)) && (rx[45:40] != cmd_out[45:40]);
    crc_err      = (rtype != R3) && (rx_crc != rx[7:1]);
    retries_left = (retry_count < MAX_R);
  end

  // Main command FSM. Every output is a register; command_complete is
  // cleared by default so it only survives the cycle it was set for.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state               <= IDLE;
      rtype               <= NONE;
      counter             <= '0;
      rx                  <= '0;
      busy                <= 1'b0;
      response            <= '0;
      command_complete    <= 1'b0;
      command_index_error <= 1'b0;
      command_timeout     <= 1'b0;
      crc_error           <= 1'b0;
      retry_count         <= 2'd0;
      strobe_out          <= 1'b0;
      cmd_out             <= '0;
      idle_out            <= 1'b1;
      ack_out             <= 1'b0;
    end else begin
      command_complete <= 1'b0;
      case (state)
        IDLE: begin
          if (new_command) begin
            state               <= SEND;
            rtype               <= resp_type_of(cmd_index);
            cmd_out             <= {START_BITS, cmd_index, cmd_argument, tx_crc, END_BIT};
            retry_count         <= 2'd0;
            response            <= '0;
            command_index_error <= 1'b0;
            command_timeout     <= 1'b0;
            crc_error           <= 1'b0;
            strobe_out          <= 1'b1;
            busy                <= 1'b1;
            idle_out            <= 1'b0;
          end
        end
        SEND: begin
          if (serial_ready) begin
            strobe_out <= 1'b0;
            counter    <= '0;
            if (rtype == NONE) begin
              state            <= DONE;
              command_complete <= 1'b1;
              ack_out          <= 1'b1;
            end else begin
              state <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          counter <= counter + 1'b1;
          if (strobe_in) begin
            rx    <= cmd_in[127:1];
            state <= CHECK;
          end else if (counter == CNT_LAST) begin
            if (retries_left) begin
              retry_count <= retry_count + 1'b1;
              strobe_out  <= 1'b1;
              state       <= SEND;
            end else begin
              command_timeout  <= 1'b1;
              command_complete <= 1'b1;
              ack_out          <= 1'b1;
              state            <= DONE;
            end
          end
        end
        CHECK: begin
          if (crc_err && retries_left) begin
            retry_count <= retry_count + 1'b1;
            strobe_out  <= 1'b1;
            state       <= SEND;
          end else begin
            command_index_error <= idx_err;
            crc_error           <= crc_err;
            case (rtype)
              R2:      response              <= {rx[127:8], 8'h00};
              R1B:     response[127:96]      <= rx[39:8];
              default: response[31:0]        <= rx[39:8];
            endcase
            command_complete <= 1'b1;
            ack_out          <= 1'b1;
            state            <= DONE;
          end
        end
        DONE: begin
          if (ack_in) begin
            ack_out  <= 1'b0;
            busy     <= 1'b0;
            idle_out <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
